// File: rtl/xbar_pkg.sv
// Shared types and constants for the configurable LUT-tile crossbar.
// Holds the config-chain state encoding and the ceil-log2 helper.
package xbar_pkg;

    localparam int XBAR_N_IN  = 38;
    localparam int XBAR_N_OUT = 50;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2
    } cfg_state_t;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/xbar_cfg_chain.sv
// Serial config chain: shadow shift register, bit counter / FSM, and the
// active store that is loaded atomically on an accepted commit.
module xbar_cfg_chain
    import xbar_pkg::*;
#(
    parameter int CFG_W = 300
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_cfg_en,
    input  logic             i_cfg_in,
    input  logic             i_cfg_commit,
    output logic             o_cfg_out,
    output logic             o_cfg_full,
    output logic             o_cfg_err,
    output logic [CFG_W-1:0] o_active
);

    localparam int               CNT_W   = clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_W);

    logic [CFG_W-1:0] r_shadow;
    logic [CFG_W-1:0] r_active;
    logic [CNT_W-1:0] r_cnt;
    cfg_state_t       r_state;
    logic             r_err;

    logic             w_commit_ok;
    logic [CNT_W-1:0] w_cnt_inc;

    // A commit coinciding with a shift is rejected so the copied image is never mid-slide.
    assign w_commit_ok = i_cfg_commit && (r_state == FULL) && !i_cfg_en;
    assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
            r_active <= '0;
            r_cnt    <= '0;
            r_state  <= EMPTY;
            r_err    <= 1'b0;
        end else begin
            if (i_cfg_en) begin
                r_shadow <= {i_cfg_in, r_shadow[CFG_W-1:1]};
            end
            if (w_commit_ok) begin
                r_active <= r_shadow;
                r_cnt    <= '0;
                r_state  <= EMPTY;
                r_err    <= 1'b0;
            end else begin
                if (i_cfg_commit) begin
                    r_err <= 1'b1;
                end
                if (i_cfg_en) begin
                    r_cnt   <= w_cnt_inc;
                    r_state <= (w_cnt_inc == CNT_MAX) ? FULL : LOADING;
                end
            end
        end
    end

    assign o_cfg_out  = r_shadow[0];
    assign o_cfg_full = (r_state == FULL);
    assign o_cfg_err  = r_err;
    assign o_active   = r_active;

endmodule

// File: rtl/xbar_cfg.sv
// Runtime-configurable N_IN x N_OUT crossbar; each output picks one input
// via a select field held in the serially loaded config chain.
module xbar_cfg
    import xbar_pkg::*;
#(
    parameter int N_IN    = XBAR_N_IN,
    parameter int N_OUT   = XBAR_N_OUT,
    parameter int SEL_W   = clog2(N_IN),
    parameter int OUT_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  io_xbar_in,
    output logic [N_OUT-1:0] io_xbar_out,
    input  logic             io_cfg_en,
    input  logic             io_cfg_in,
    output logic             io_cfg_out,
    input  logic             io_cfg_commit,
    output logic             io_cfg_full,
    output logic             io_cfg_err
);

    localparam int               CFG_W  = N_OUT * SEL_W;
    localparam logic [SEL_W:0]   N_IN_W = (SEL_W + 1)'(N_IN);

    logic [CFG_W-1:0] w_active;
    logic [N_OUT-1:0] w_mux;

    xbar_cfg_chain #(
        .CFG_W (CFG_W)
    ) u_chain (
        .clk          (clk),
        .reset        (reset),
        .i_cfg_en     (io_cfg_en),
        .i_cfg_in     (io_cfg_in),
        .i_cfg_commit (io_cfg_commit),
        .o_cfg_out    (io_cfg_out),
        .o_cfg_full   (io_cfg_full),
        .o_cfg_err    (io_cfg_err),
        .o_active     (w_active)
    );

    // Unused select codes (>= N_IN) route a constant 0 so the output is never X.
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_mux
        logic [SEL_W-1:0] w_sel;
        assign w_sel     = w_active[gi*SEL_W +: SEL_W];
        assign w_mux[gi] = ({1'b0, w_sel} < N_IN_W) ? io_xbar_in[w_sel] : 1'b0;
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [N_OUT-1:0] r_xbar_out;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_xbar_out <= '0;
            end else begin
                r_xbar_out <= w_mux;
            end
        end
        assign io_xbar_out = r_xbar_out;
    end else begin : g_out_comb
        // Force zero during reset; the cleared store would otherwise route in[0].
        assign io_xbar_out = reset ? '0 : w_mux;
    end

endmodule

// File: tb/tb_xbar_cfg.sv
// Directed bench for xbar_cfg: scoreboarded routing checks plus config-chain
// state, error, chaining and reset behaviour.
module tb_xbar_cfg;

    localparam int N_IN  = 38;
    localparam int N_OUT = 50;
    localparam int SEL_W = 6;
    localparam int CFG_W = N_OUT * SEL_W;

    logic             clk;
    logic             reset;
    logic [N_IN-1:0]  xbar_in;
    logic [N_OUT-1:0] xbar_out;
    logic             cfg_en;
    logic             cfg_in;
    logic             cfg_out;
    logic             cfg_commit;
    logic             cfg_full;
    logic             cfg_err;

    int vectors     = 0;
    int miscompares = 0;

    int               model_sel [N_OUT];
    int               cfg_sel   [N_OUT];
    logic [N_OUT-1:0] sb_q [$];
    logic             bit_q [$];

    xbar_cfg #(
        .N_IN    (N_IN),
        .N_OUT   (N_OUT),
        .SEL_W   (SEL_W),
        .OUT_REG (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .io_xbar_in    (xbar_in),
        .io_xbar_out   (xbar_out),
        .io_cfg_en     (cfg_en),
        .io_cfg_in     (cfg_in),
        .io_cfg_out    (cfg_out),
        .io_cfg_commit (cfg_commit),
        .io_cfg_full   (cfg_full),
        .io_cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_OUT-1:0] route(input logic [N_IN-1:0] v);
        logic [N_OUT-1:0] r;
        r = '0;
        for (int i = 0; i < N_OUT; i++) begin
            r[i] = (model_sel[i] < N_IN) ? v[model_sel[i]] : 1'b0;
        end
        return r;
    endfunction

    function automatic logic [CFG_W-1:0] pack_sel();
        logic [CFG_W-1:0] vec;
        vec = '0;
        for (int i = 0; i < N_OUT; i++) begin
            vec[i*SEL_W +: SEL_W] = SEL_W'(cfg_sel[i]);
        end
        return vec;
    endfunction

    task automatic set_model(input logic [CFG_W-1:0] vec);
        for (int i = 0; i < N_OUT; i++) begin
            model_sel[i] = int'(vec[i*SEL_W +: SEL_W]);
        end
    endtask

    task automatic shift_bits(input logic [CFG_W-1:0] vec, input int lo, input int hi);
        for (int k = lo; k < hi; k++) begin
            cfg_en = 1'b1;
            cfg_in = vec[k];
            step();
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
    endtask

    task automatic apply(input string tag, input logic [N_IN-1:0] v);
        xbar_in = v;
        sb_q.push_back(route(v));
        step();
        check(tag, xbar_out, sb_q.pop_front());
        $display("apply %s in=%h out=%h", tag, v, xbar_out);
    endtask

    function automatic logic [N_IN-1:0] rnd_in();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[N_IN-1:0];
    endfunction

    initial begin
        logic [CFG_W-1:0] vec;
        logic [CFG_W-1:0] shifted;
        logic [599:0]     stream;
        logic             exp_bit;

        for (int i = 0; i < N_OUT; i++) model_sel[i] = 0;
        reset      = 1'b1;
        xbar_in    = '0;
        cfg_en     = 1'b0;
        cfg_in     = 1'b0;
        cfg_commit = 1'b0;
        step();
        step();
        check("rst_out",  xbar_out, 64'd0);
        check("rst_full", cfg_full, 64'd0);
        check("rst_err",  cfg_err,  64'd0);
        check("rst_cout", cfg_out,  64'd0);
        reset = 1'b0;

        apply("post_reset_ones", '1);
        commit();
        check("commit_empty_err", cfg_err, 64'd1);

        // Asynchronous reset asserted mid-cycle during traffic.
        xbar_in = 38'h2A_AAAA_AAAB;
        step();
        #2 reset = 1'b1;
        #1;
        check("async_rst_out",  xbar_out, 64'd0);
        check("async_rst_full", cfg_full, 64'd0);
        check("async_rst_err",  cfg_err,  64'd0);
        step();
        step();
        reset = 1'b0;
        apply("reset_ones", '1);
        check("reset_ones_const", xbar_out, 64'h3_FFFF_FFFF_FFFF);

        // Full load of sel_i = i % N_IN.
        for (int i = 0; i < N_OUT; i++) cfg_sel[i] = i % N_IN;
        vec = pack_sel();
        shift_bits(vec, 0, CFG_W - 1);
        check("full_at_299", cfg_full, 64'd0);
        shift_bits(vec, CFG_W - 1, CFG_W);
        check("full_at_300", cfg_full, 64'd1);
        commit();
        set_model(vec);
        check("full_after_commit", cfg_full, 64'd0);
        check("err_after_commit",  cfg_err,  64'd0);
        apply("mod_route_5555", 38'h15_5555_5555);
        for (int t = 0; t < 3; t++) apply("mod_route_rnd", rnd_in());

        // Out-of-range select on output 0.
        cfg_sel[0] = 63;
        for (int i = 1; i < N_OUT; i++) cfg_sel[i] = N_IN - 1;
        vec = pack_sel();
        shift_bits(vec, 0, CFG_W);
        commit();
        set_model(vec);
        apply("oor_ones", '1);
        check("oor_const", xbar_out, 64'h3_FFFF_FFFF_FFFE);

        // Early commit rejected, then accepted after the last bit.
        for (int i = 0; i < N_OUT; i++) cfg_sel[i] = (i * 7 + 3) % N_IN;
        vec = pack_sel();
        shift_bits(vec, 0, CFG_W - 1);
        commit();
        check("early_err",  cfg_err,  64'd1);
        check("early_full", cfg_full, 64'd0);
        apply("early_old_route", rnd_in());
        shift_bits(vec, CFG_W - 1, CFG_W);
        check("late_full", cfg_full, 64'd1);
        commit();
        set_model(vec);
        check("late_err", cfg_err, 64'd0);
        apply("late_new_route", rnd_in());
        apply("late_new_route", rnd_in());

        // Commit coincident with a shift while FULL.
        for (int i = 0; i < N_OUT; i++) cfg_sel[i] = N_IN - 1 - (i % N_IN);
        vec = pack_sel();
        shift_bits(vec, 0, CFG_W);
        check("cws_full_before", cfg_full, 64'd1);
        cfg_en     = 1'b1;
        cfg_in     = 1'b1;
        cfg_commit = 1'b1;
        step();
        cfg_en     = 1'b0;
        cfg_in     = 1'b0;
        cfg_commit = 1'b0;
        check("cws_err",  cfg_err,  64'd1);
        check("cws_full", cfg_full, 64'd1);
        apply("cws_old_route", rnd_in());
        shifted = {1'b1, vec[CFG_W-1:1]};
        commit();
        set_model(shifted);
        check("cws_commit_err", cfg_err, 64'd0);
        apply("cws_shifted_route", rnd_in());

        // Chaining: io_cfg_out is io_cfg_in delayed by CFG_W shifts.
        for (int k = 0; k < 600; k++) stream[k] = 1'($urandom);
        for (int k = 0; k < 600; k++) begin
            bit_q.push_back(stream[k]);
            cfg_en = 1'b1;
            cfg_in = stream[k];
            step();
            if (bit_q.size() == CFG_W) begin
                exp_bit = bit_q.pop_front();
                check("chain_out", cfg_out, 64'(exp_bit));
            end
        end
        cfg_en = 1'b0;
        $display("chain 600 bits shifted, %0d checked", 600 - CFG_W + 1);

        // Reset mid-load returns to EMPTY.
        reset = 1'b1;
        step();
        reset = 1'b0;
        shift_bits(stream[CFG_W-1:0], 0, 150);
        #2 reset = 1'b1;
        #1;
        check("midload_rst_full", cfg_full, 64'd0);
        check("midload_rst_cout", cfg_out,  64'd0);
        step();
        reset = 1'b0;
        vec = '1;
        shift_bits(vec, 0, CFG_W - 1);
        check("reload_full_299", cfg_full, 64'd0);
        shift_bits(vec, CFG_W - 1, CFG_W);
        check("reload_full_300", cfg_full, 64'd1);
        check("reload_cout",     cfg_out,  64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
